// File: rtl/serial_slave.sv
// ---------------------------------------------------------------------------
// serial_slave
//
// Slave end of the serial master/slave bus. It receives a 14-bit address
// (MSB first) and, for write frames, 8 data bits (MSB first) from the
// master. Write data is stored in a local byte memory. A read is answered
// with a one-cycle slave_valid strobe, followed by 8 data bits (MSB first)
// on data_out.
//
// Parameters:
//   MEM_AW    memory address width; depth is 2^MEM_AW bytes
//   SLAVE_ID  value the top two address bits must match (address check only)
//   RESP_LAT  idle cycles between the last address bit and slave_valid (0..15)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   valid        in   one-cycle frame-start strobe from the master
//   valid_s      in   frame-active level from the master
//   write_en     in   1 = write frame, 0 = read frame (sampled at frame start)
//   addr_rx      in   serial address bit
//   data_rx_w    in   serial write-data bit
//   data_out     out  serial read-data bit to the master (0 outside TX)
//   slave_valid  out  one-cycle read-response strobe
//   slave_busy   out  high whenever the slave is not idle
//
// Build option:
//   SLAVE_ADDR_CHECK_EN  when defined, frames whose addr[13:12] differ from
//                        SLAVE_ID are dropped at the end of the address phase.
//
// Memory contents are deliberately not reset and survive reset_n.
// ---------------------------------------------------------------------------
module serial_slave #(
    parameter int         MEM_AW   = 12,
    parameter logic [1:0] SLAVE_ID = 2'b00,
    parameter int         RESP_LAT = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic valid,
    input  logic valid_s,
    input  logic write_en,
    input  logic addr_rx,
    input  logic data_rx_w,
    output logic data_out,
    output logic slave_valid,
    output logic slave_busy
);

    typedef enum logic [2:0] {
        IDLE,
        RX,
        COMMIT,
        WAIT,
        RESP,
        TX
    } state_t;

    // Terminal value of the wait counter; unused when RESP_LAT is 0.
    localparam logic [3:0] LAT_LAST = 4'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;          // RX bit index, WAIT cycles, or TX bit index
    logic        is_write;
    logic [13:0] addr_sr;
    logic [7:0]  data_sr;
    logic [7:0]  tx_sr;
    logic [13:0] addr_next;
    logic        last_bit;
    logic        id_ok;
    logic [MEM_AW-1:0] rd_idx;
    logic        unused_top_bit;

    logic [7:0] mem [0:(1 << MEM_AW)-1];

    // Address register value after this edge's shift; used so the decision
    // at the last address bit sees the complete address.
    assign addr_next = {addr_sr[12:0], addr_rx};
    assign last_bit  = (cnt == 4'd13);

    // The ID check is done on addr_next, so the registered MSB is never read.
    assign unused_top_bit = addr_sr[13];

`ifdef SLAVE_ADDR_CHECK_EN
    assign id_ok = (addr_next[13:12] == SLAVE_ID);
`else
    assign id_ok = 1'b1;
`endif

    // With RESP_LAT = 0 RESP is entered straight from RX, before addr_sr
    // holds the final bit, so the read index is taken from addr_next.
    assign rd_idx = (state == RX) ? addr_next[MEM_AW-1:0] : addr_sr[MEM_AW-1:0];

    // Next-state and output decode. Outputs depend only on the registered
    // state so that reset_n clears them immediately.
    always_comb begin
        state_next  = state;
        data_out    = 1'b0;
        slave_valid = 1'b0;
        slave_busy  = (state != IDLE);
        case (state)
            IDLE: begin
                if (valid && valid_s) state_next = RX;
            end
            RX: begin
                if (!valid_s) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    if (!id_ok)             state_next = IDLE;
                    else if (is_write)      state_next = COMMIT;
                    else if (RESP_LAT == 0) state_next = RESP;
                    else                    state_next = WAIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            WAIT: begin
                if (cnt == LAT_LAST) state_next = RESP;
            end
            RESP: begin
                slave_valid = 1'b1;
                state_next  = TX;
            end
            TX: begin
                data_out = tx_sr[7];
                if (cnt == 4'd7) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            is_write <= 1'b0;
            addr_sr  <= 14'd0;
            data_sr  <= 8'd0;
            tx_sr    <= 8'd0;
        end else begin
            state <= state_next;

            if (state_next == RESP && state != RESP) begin
                tx_sr <= mem[rd_idx];
            end

            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (valid && valid_s) is_write <= write_en;
                end
                RX: begin
                    if (valid_s) begin
                        addr_sr <= addr_next;
                        // Data bits arrive alongside the last 8 address bits.
                        if (cnt >= 4'd6) data_sr <= {data_sr[6:0], data_rx_w};
                    end
                    cnt <= (state_next == RX) ? cnt + 4'd1 : 4'd0;
                end
                WAIT: begin
                    cnt <= (state_next == WAIT) ? cnt + 4'd1 : 4'd0;
                end
                TX: begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                    cnt   <= cnt + 4'd1;
                end
                default: begin
                    cnt <= 4'd0;
                end
            endcase
        end
    end

    // Byte memory: written only from COMMIT, no reset so contents persist.
    always_ff @(posedge clock) begin
        if (state == COMMIT) mem[addr_sr[MEM_AW-1:0]] <= data_sr;
    end

endmodule

// File: tb/tb_serial_slave.sv
// ---------------------------------------------------------------------------
// tb_serial_slave
//
// Bench for serial_slave. Two instances share the same bus inputs: one with
// RESP_LAT = 2 and one with RESP_LAT = 0, so every frame exercises both
// response latencies. Expected waveforms are derived from a byte-array model
// of the memory and the frame timing rules (response strobe, data bits and
// busy window expressed as cycle offsets from the frame start).
// ---------------------------------------------------------------------------
module tb_serial_slave;

    localparam logic [1:0] ID = 2'b01;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic valid = 1'b0;
    logic valid_s = 1'b0;
    logic write_en = 1'b0;
    logic addr_rx = 1'b0;
    logic data_rx_w = 1'b0;
    logic do2, sv2, sb2;
    logic do0, sv0, sb0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  mem_m [0:4095];
    logic [11:0] wr_q [$];

    always #5 clock = ~clock;

    serial_slave #(.MEM_AW(12), .SLAVE_ID(ID), .RESP_LAT(2)) dut (
        .clock(clock), .reset_n(reset_n), .valid(valid), .valid_s(valid_s),
        .write_en(write_en), .addr_rx(addr_rx), .data_rx_w(data_rx_w),
        .data_out(do2), .slave_valid(sv2), .slave_busy(sb2)
    );

    serial_slave #(.MEM_AW(12), .SLAVE_ID(ID), .RESP_LAT(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .valid(valid), .valid_s(valid_s),
        .write_en(write_en), .addr_rx(addr_rx), .data_rx_w(data_rx_w),
        .data_out(do0), .slave_valid(sv0), .slave_busy(sb0)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Address whose ID bits are accepted by the build under test; in the
    // default build the ID bits are random to exercise index wrap.
    function automatic logic [13:0] mk_addr(input logic [11:0] lo);
`ifdef SLAVE_ADDR_CHECK_EN
        return {ID, lo};
`else
        return {2'($urandom_range(3, 0)), lo};
`endif
    endfunction

    function automatic bit accepted(input logic [13:0] a);
`ifdef SLAVE_ADDR_CHECK_EN
        return (a[13:12] == ID);
`else
        return (a[13:12] == a[13:12]) || 1'b1;
`endif
    endfunction

    // Drives valid at the current time (edge S follows), then 14 address
    // bits and 8 data bits. valid_s is dropped from bit abort_k on (0 = never).
    // Returns 1 time unit after edge S+14.
    task automatic start_frame(input logic we, input logic [13:0] a,
                               input logic [7:0] d, input int abort_k);
        bit dropped = 1'b0;
        valid = 1'b1;
        valid_s = 1'b1;
        write_en = we;
        @(posedge clock); #1;
        valid = 1'b0;
        write_en = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            addr_rx = a[4'(14 - k)];
            if (k >= 7) data_rx_w = d[3'(14 - k)];
            else        data_rx_w = 1'b0;
            if (k == abort_k) dropped = 1'b1;
            valid_s = ~dropped;
            @(posedge clock); #1;
        end
        valid_s = 1'b0;
        addr_rx = 1'b0;
        data_rx_w = 1'b0;
    endtask

    task automatic write_frame(input logic [13:0] a, input logic [7:0] d,
                               input int abort_k);
        bit acc;
        acc = accepted(a) && (abort_k == 0);
        start_frame(1'b1, a, d, abort_k);
        #3;
        chk1($sformatf("wr %h busy c14 L2", a), sb2, acc);
        chk1($sformatf("wr %h busy c14 L0", a), sb0, acc);
        if (acc) begin
            mem_m[a[11:0]] = d;
            wr_q.push_back(a[11:0]);
        end
        @(posedge clock); #4;
        chk1($sformatf("wr %h busy c15 L2", a), sb2, 1'b0);
        chk1($sformatf("wr %h busy c15 L0", a), sb0, 1'b0);
    endtask

    task automatic check_inst(input int c, input int lat, input logic sv,
                              input logic dout, input logic busy,
                              input logic [7:0] b, input bit acc,
                              input logic [13:0] a);
        logic exp_v, exp_d, exp_b;
        exp_v = acc && (c == 14 + lat);
        exp_b = acc && (c <= 22 + lat);
        exp_d = 1'b0;
        if (acc && c >= 15 + lat && c <= 22 + lat) exp_d = b[3'(7 - (c - 15 - lat))];
        chk1($sformatf("rd %h L%0d c%0d slave_valid", a, lat, c), sv, exp_v);
        chk1($sformatf("rd %h L%0d c%0d data_out", a, lat, c), dout, exp_d);
        chk1($sformatf("rd %h L%0d c%0d slave_busy", a, lat, c), busy, exp_b);
    endtask

    // Read frame; checks both instances every cycle from c = 14 to 26, where
    // cycle c is the one following edge S+c. strobe_c injects a stray valid
    // strobe; rst_c asserts reset_n mid-cycle and returns with reset held.
    task automatic read_frame(input logic [13:0] a, input int strobe_c,
                              input int rst_c);
        bit acc;
        logic [7:0] b;
        acc = accepted(a);
        b = mem_m[a[11:0]];
        start_frame(1'b0, a, 8'h00, 0);
        for (int c = 14; c <= 26; c++) begin
            if (c > 14) begin
                @(posedge clock); #1;
                valid = 1'b0;
                valid_s = 1'b0;
            end
            #3;
            check_inst(c, 2, sv2, do2, sb2, b, acc, a);
            check_inst(c, 0, sv0, do0, sb0, b, acc, a);
            if (c == strobe_c) begin
                valid = 1'b1;
                valid_s = 1'b1;
            end
            if (c == rst_c) begin
                reset_n = 1'b0;
                #1;
                chk1("async rst data_out L2", do2, 1'b0);
                chk1("async rst slave_valid L2", sv2, 1'b0);
                chk1("async rst slave_busy L2", sb2, 1'b0);
                chk1("async rst data_out L0", do0, 1'b0);
                chk1("async rst slave_valid L0", sv0, 1'b0);
                chk1("async rst slave_busy L0", sb0, 1'b0);
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] lo;
        // Reset state
        #12;
        chk1("reset data_out L2", do2, 1'b0);
        chk1("reset slave_valid L2", sv2, 1'b0);
        chk1("reset slave_busy L2", sb2, 1'b0);
        chk1("reset data_out L0", do0, 1'b0);
        chk1("reset slave_valid L0", sv0, 1'b0);
        chk1("reset slave_busy L0", sb0, 1'b0);
        #5;
        reset_n = 1'b1;

        // Basic write/read, two addresses including the top of memory
        write_frame(mk_addr(12'h123), 8'hA5, 0);
        read_frame(mk_addr(12'h123), -1, -1);
        write_frame(mk_addr(12'hFFF), 8'h3C, 0);
        read_frame(mk_addr(12'hFFF), -1, -1);

        // Aborted write leaves the old byte in place
        write_frame(mk_addr(12'h010), 8'h5A, 0);
        write_frame(mk_addr(12'h010), 8'hFF, 9);
        read_frame(mk_addr(12'h010), -1, -1);

`ifdef SLAVE_ADDR_CHECK_EN
        // Foreign ID is dropped; own ID answers
        write_frame(14'h1010, 8'hC3, 0);
        read_frame(14'h2010, -1, -1);
        read_frame(14'h1010, -1, -1);
`else
        // Top address bits ignored; index wraps
        write_frame(14'h3010, 8'h77, 0);
        read_frame(14'h0010, -1, -1);
`endif

        // Stray valid during WAIT is ignored
        read_frame(mk_addr(12'h123), 15, -1);

        // Reset during TX, memory survives
        read_frame(mk_addr(12'hFFF), -1, 19);
        #2;
        reset_n = 1'b1;
        read_frame(mk_addr(12'hFFF), -1, -1);

        // Random writes followed by random reads of written locations
        for (int i = 0; i < 12; i++) begin
            lo = 12'($urandom_range(4095, 0));
            write_frame(mk_addr(lo), 8'($urandom_range(255, 0)), 0);
        end
        for (int i = 0; i < 12; i++) begin
            lo = wr_q[$urandom_range(wr_q.size() - 1, 0)];
            read_frame(mk_addr(lo), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
